// File: rtl/fft_loader_pkg.sv
// Shared types and register layout for the FFT sample loader.
// Included by the loader top and its register readback block.
package fft_loader_pkg;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam logic [1:0] REG_RSVD   = 2'd3;

   localparam int CTRL_START = 0;
   localparam int CTRL_ABORT = 1;
   localparam int CTRL_AUTO  = 2;

   localparam int STAT_LOAD = 0;
   localparam int STAT_RUN  = 1;
   localparam int STAT_OVF  = 2;
   localparam int STAT_FULL = 3;
   localparam int STAT_BUSY = 4;

endpackage

// File: rtl/fft_loader_regs.sv
// Register readback for the FFT loader: CTRL/STATUS/COUNT mux.
// Read data and valid are registered one cycle after the access.
module fft_loader_regs
   import fft_loader_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 9
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              rd,
   input  logic              is_reg,
   input  logic [1:0]        offset,
   input  logic              auto_en,
   input  logic              load,
   input  logic              run,
   input  logic              overflow,
   input  logic              full,
   input  logic              busy,
   input  logic [CNT_W-1:0]  count,
   output logic [DATA_W-1:0] readdata,
   output logic              readdatavalid
);

   logic [DATA_W-1:0] mux;

   always_comb begin
      mux = '0;
      if (is_reg) begin
         unique case (offset)
            REG_CTRL: mux[CTRL_AUTO] = auto_en;
            REG_STATUS: begin
               mux[STAT_LOAD] = load;
               mux[STAT_RUN]  = run;
               mux[STAT_OVF]  = overflow;
               mux[STAT_FULL] = full;
               mux[STAT_BUSY] = busy;
            end
            REG_COUNT: mux[CNT_W-1:0] = count;
            REG_RSVD: mux = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         readdata      <= '0;
         readdatavalid <= 1'b0;
      end else begin
         readdatavalid <= rd;
         readdata      <= rd ? mux : '0;
      end
   end

endmodule

// File: rtl/fft_avmm_loader.sv
// Avalon-MM slave loading multi-channel FFT samples and
// sequencing FFT start/done through a LOAD/START/RUN machine.
module fft_avmm_loader
   import fft_loader_pkg::*;
#(
   parameter int SAMPLE_W   = 16,
   parameter int DATA_W     = 32,
   parameter int DEPTH      = 256,
   parameter int NUM_CH     = 1,
   parameter int ADDR_W     = 9,
   parameter bit AUTO_START = 1'b0,
   localparam int IDX_W = $clog2(DEPTH),
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                slave_chipselect,
   input  logic                slave_write,
   input  logic                slave_read,
   input  logic [ADDR_W-1:0]   slave_address,
   input  logic [DATA_W-1:0]   slave_writedata,
   output logic [DATA_W-1:0]   slave_readdata,
   output logic                slave_readdatavalid,
   input  logic                fft_busy,
   input  logic                fft_done,
   output logic                sWriteEn,
   output logic [IDX_W-1:0]    wAddress,
   output logic [CH_W-1:0]     wChannel,
   output logic [SAMPLE_W-1:0] fft_init_data,
   output logic                fft_start
);

   localparam int TOTAL = DEPTH * NUM_CH;
   localparam int CNT_W = $clog2(TOTAL + 1);
   localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);

   state_t           state;
   logic [CNT_W-1:0] count;
   logic             overflow;
   logic             auto_en;

   logic wr, rd, is_reg;
   logic smp_wr, ctrl_wr;
   logic abort, go, to_run, to_load;
   logic full;
   logic [1:0]       offset;
   logic [IDX_W-1:0] idx;
   logic [CH_W-1:0]  ch;
   logic             unused_bits;

   assign wr      = slave_chipselect & slave_write;
   assign rd      = slave_chipselect & slave_read;
   assign is_reg  = slave_address[ADDR_W-1];
   assign offset  = slave_address[1:0];
   assign idx     = slave_address[IDX_W-1:0];
   assign smp_wr  = wr & ~is_reg;
   assign ctrl_wr = wr & is_reg & (offset == REG_CTRL);
   assign full    = (count == TOTAL_C);

   if (NUM_CH > 1) begin : g_ch
      assign ch = slave_address[IDX_W +: CH_W];
   end else begin : g_one
      assign ch = '0;
   end

   assign unused_bits = ^{slave_address, slave_writedata};

   // Mutually exclusive transition terms; abort overrides everything.
   assign abort   = ctrl_wr & slave_writedata[CTRL_ABORT];
   assign go      = ~abort & (state == ST_LOAD) &
                    ((ctrl_wr & slave_writedata[CTRL_START]) |
                     (auto_en & full));
   assign to_run  = ~abort & (state == ST_START);
   assign to_load = ~abort & (state == ST_RUN) & fft_done;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state         <= ST_LOAD;
         count         <= '0;
         overflow      <= 1'b0;
         auto_en       <= AUTO_START;
         sWriteEn      <= 1'b0;
         wAddress      <= '0;
         wChannel      <= '0;
         fft_init_data <= '0;
         fft_start     <= 1'b0;
      end else begin
         sWriteEn  <= 1'b0;
         fft_start <= 1'b0;
         if (smp_wr) begin
            if (state == ST_LOAD) begin
               sWriteEn      <= 1'b1;
               wAddress      <= idx;
               wChannel      <= ch;
               fft_init_data <= slave_writedata[SAMPLE_W-1:0];
               if (!full) count <= count + 1'b1;
            end else begin
               overflow <= 1'b1;
            end
         end
         if (ctrl_wr) auto_en <= slave_writedata[CTRL_AUTO];
         unique case (1'b1)
            abort: begin
               state    <= ST_LOAD;
               count    <= '0;
               overflow <= 1'b0;
            end
            go: begin
               state     <= ST_START;
               fft_start <= 1'b1;
            end
            to_run: state <= ST_RUN;
            to_load: begin
               state <= ST_LOAD;
               count <= '0;
            end
            default: ;
         endcase
      end
   end

   fft_loader_regs #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_regs (
      .clk           (clk),
      .n_rst         (n_rst),
      .rd            (rd),
      .is_reg        (is_reg),
      .offset        (offset),
      .auto_en       (auto_en),
      .load          (state == ST_LOAD),
      .run           (state != ST_LOAD),
      .overflow      (overflow),
      .full          (full),
      .busy          (fft_busy),
      .count         (count),
      .readdata      (slave_readdata),
      .readdatavalid (slave_readdatavalid)
   );

endmodule

// File: tb/tb_fft_avmm_loader.sv
// Randomized bench for fft_avmm_loader against a transaction-level model.
// Second instance covers the multi-channel address split.
module tb_fft_avmm_loader;

   localparam int TOTAL = 256;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        n_rst;
   logic        cs, wr, rd, busy, done;
   logic [8:0]  addr;
   logic [31:0] wd;
   logic [31:0] rdata;
   logic        rdv, we, start;
   logic [7:0]  waddr;
   logic [0:0]  wch;
   logic [15:0] wdat;

   logic        b_cs, b_wr;
   logic [8:0]  b_addr;
   logic [31:0] b_wd;
   logic [31:0] b_rdata;
   logic        b_rdv, b_we, b_start;
   logic [5:0]  b_waddr;
   logic [1:0]  b_wch;
   logic [15:0] b_wdat;

   fft_avmm_loader dut (
      .clk                 (clk),
      .n_rst               (n_rst),
      .slave_chipselect    (cs),
      .slave_write         (wr),
      .slave_read          (rd),
      .slave_address       (addr),
      .slave_writedata     (wd),
      .slave_readdata      (rdata),
      .slave_readdatavalid (rdv),
      .fft_busy            (busy),
      .fft_done            (done),
      .sWriteEn            (we),
      .wAddress            (waddr),
      .wChannel            (wch),
      .fft_init_data       (wdat),
      .fft_start           (start)
   );

   fft_avmm_loader #(.DEPTH(64), .NUM_CH(4)) dut_mc (
      .clk                 (clk),
      .n_rst               (n_rst),
      .slave_chipselect    (b_cs),
      .slave_write         (b_wr),
      .slave_read          (1'b0),
      .slave_address       (b_addr),
      .slave_writedata     (b_wd),
      .slave_readdata      (b_rdata),
      .slave_readdatavalid (b_rdv),
      .fft_busy            (1'b0),
      .fft_done            (1'b0),
      .sWriteEn            (b_we),
      .wAddress            (b_waddr),
      .wChannel            (b_wch),
      .fft_init_data       (b_wdat),
      .fft_start           (b_start)
   );

   int vectors    = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Model: phase 0 = loading, 1 = start pulse, 2 = running.
   int m_phase;
   int m_count;
   bit m_ovf;
   bit m_auto;

   task automatic model_reset();
      m_phase = 0;
      m_count = 0;
      m_ovf   = 1'b0;
      m_auto  = 1'b0;
   endtask

   // One bus cycle: drive at negedge, predict, check 1ns after posedge.
   task automatic step(input logic c, input logic w, input logic r,
                       input logic [8:0] a, input logic [31:0] d,
                       input logic dn, input logic bz);
      logic        e_we, e_rdv, is_ctrl, wants_start;
      logic [31:0] e_rd;
      logic [7:0]  e_a;
      logic [15:0] e_d;
      int          nxt;
      cs = c; wr = w; rd = r; addr = a; wd = d; done = dn; busy = bz;
      e_we = 1'b0; e_a = '0; e_d = '0; e_rd = '0;
      e_rdv = c & r;
      if (e_rdv && a[8]) begin
         case (a[1:0])
            2'd0: e_rd = m_auto ? 32'h4 : 32'h0;
            2'd1: e_rd = (bz ? 32'h10 : 0) + (m_count == TOTAL ? 8 : 0) +
                         (m_ovf ? 4 : 0) + (m_phase != 0 ? 2 : 0) +
                         (m_phase == 0 ? 1 : 0);
            2'd2: e_rd = m_count;
            default: e_rd = '0;
         endcase
      end
      wants_start = m_auto && (m_count == TOTAL);
      is_ctrl = c && w && a[8] && (a[1:0] == 2'd0);
      if (c && w && !a[8]) begin
         if (m_phase == 0) begin
            e_we = 1'b1; e_a = a[7:0]; e_d = d[15:0];
            m_count = (m_count + 1 > TOTAL) ? TOTAL : m_count + 1;
         end else m_ovf = 1'b1;
      end
      nxt = m_phase;
      if (is_ctrl) begin
         m_auto = d[2];
         if (d[0]) wants_start = 1'b1;
      end
      if (is_ctrl && d[1]) begin
         nxt = 0; m_count = 0; m_ovf = 1'b0;
      end else if (m_phase == 0) begin
         if (wants_start) nxt = 1;
      end else if (m_phase == 1) nxt = 2;
      else if (dn) begin
         nxt = 0; m_count = 0;
      end
      m_phase = nxt;
      @(posedge clk); #1;
      chk("sWriteEn", we, e_we);
      if (e_we) begin
         chk("wAddress", waddr, e_a);
         chk("wChannel", wch, 0);
         chk("fft_init_data", wdat, e_d);
      end
      chk("fft_start", start, nxt == 1);
      chk("readdatavalid", rdv, e_rdv);
      if (e_rdv) chk("readdata", rdata, e_rd);
      @(negedge clk);
   endtask

   task automatic idle();
      step(0, 0, 0, '0, '0, 0, 0);
   endtask
   task automatic rd_reg(input logic [1:0] off);
      step(1, 0, 1, {7'b1000000, off}, '0, 0, 0);
   endtask
   task automatic wr_ctrl(input logic [31:0] d);
      step(1, 1, 0, 9'h100, d, 0, 0);
   endtask
   task automatic wr_smp(input logic [8:0] a, input logic [31:0] d);
      step(1, 1, 0, a, d, 0, 0);
   endtask

   initial begin
      int pulses;
      int r;
      cs = 0; wr = 0; rd = 0; addr = '0; wd = '0; busy = 0; done = 0;
      b_cs = 0; b_wr = 0; b_addr = '0; b_wd = '0;
      model_reset();
      n_rst = 1'b0;
      #7;
      chk("rst_sWriteEn", we, 0);
      chk("rst_fft_start", start, 0);
      chk("rst_readdatavalid", rdv, 0);
      chk("rst_readdata", rdata, 0);
      #3 n_rst = 1'b1;
      @(negedge clk);
      rd_reg(1); chk("status_after_reset", rdata, 32'h01);
      rd_reg(2); chk("count_after_reset", rdata, 32'h0);

      wr_smp(9'h005, 32'h1ABCD);
      chk("t2_we", we, 1); chk("t2_addr", waddr, 5);
      chk("t2_data", wdat, 32'hABCD);
      rd_reg(2); chk("t2_count", rdata, 1);

      wr_ctrl(32'h2);
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         wr_smp(9'h033, $urandom);
         pulses += we;
      end
      idle(); pulses += we;
      chk("t3_pulses", pulses, 3);
      rd_reg(2); chk("t3_count", rdata, 3);

      wr_ctrl(32'h6);
      for (int i = 0; i < TOTAL; i++) wr_smp(9'(i), $urandom);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         idle(); pulses += start;
      end
      chk("t4_start_pulses", pulses, 1);
      rd_reg(1); chk("t4_status_run", rdata, 32'h0A);
      step(0, 0, 0, '0, '0, 1, 0);
      rd_reg(1); chk("t4_status_done", rdata, 32'h01);
      rd_reg(2); chk("t4_count_done", rdata, 0);

      wr_ctrl(32'h1);
      idle();
      wr_smp(9'h010, 32'h5555);
      chk("t5_no_we", we, 0);
      rd_reg(1); chk("t5_status_ovf", rdata, 32'h06);
      wr_ctrl(32'h2);
      rd_reg(1); chk("t5_status_abort", rdata, 32'h01);

      @(negedge clk);
      b_cs = 1; b_wr = 1; b_addr = 9'h0C5; b_wd = 32'h0000_7E3A;
      @(posedge clk); #1;
      chk("t6_we", b_we, 1); chk("t6_ch", b_wch, 3);
      chk("t6_addr", b_waddr, 5); chk("t6_data", b_wdat, 32'h7E3A);
      @(negedge clk);
      b_addr = 9'h100; b_wd = 32'h3;
      @(posedge clk); #1;
      chk("t6_abort_we", b_we, 0); chk("t6_abort_start", b_start, 0);
      @(negedge clk);
      b_cs = 0; b_wr = 0;
      @(posedge clk); #1;
      chk("t6_abort_start2", b_start, 0);
      @(negedge clk);

      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 55)
            wr_smp({1'b0, 8'($urandom)}, $urandom);
         else if (r < 70)
            rd_reg(2'($urandom));
         else if (r < 73)
            step(1, 0, 1, {1'b0, 8'($urandom)}, '0, 0, 0);
         else if (r < 74)
            wr_ctrl($urandom & 32'h7);
         else if (r < 80)
            step(0, 0, 0, '0, '0, 1, 1'($urandom));
         else if (r < 85)
            step(0, 1, 1, 9'($urandom), $urandom, 0, 0);
         else
            step(0, 0, 0, '0, '0, 0, 1'($urandom));
      end

      wr_ctrl(32'h1);
      idle();
      rd_reg(1);
      #2 n_rst = 1'b0;
      #1;
      chk("midrun_rst_we", we, 0);
      chk("midrun_rst_start", start, 0);
      chk("midrun_rst_rdv", rdv, 0);
      chk("midrun_rst_rdata", rdata, 0);
      @(negedge clk);
      n_rst = 1'b1;
      model_reset();
      idle();
      rd_reg(1); chk("midrun_status", rdata, 32'h01);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
